// File: rtl/alu_writeback_regfile_pkg.sv
// alu_writeback_regfile_pkg: shared widths, ALU control codes and write-back queue entry type.
package alu_writeback_regfile_pkg;
  localparam int DATA_W     = 64;
  localparam int REG_ADDR_W = 5;
  localparam int NREGS      = 32;
  localparam int WBQ_DEPTH  = 2;
  localparam logic [REG_ADDR_W-1:0] XZR = 5'd31;
  typedef enum logic [3:0] {
    ALU_AND   = 4'b0000,
    ALU_OR    = 4'b0001,
    ALU_ADD   = 4'b0010,
    ALU_SUB   = 4'b0110,
    ALU_PASSB = 4'b0111
  } alu_ctrl_e;
  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
    logic                  zero;
    logic                  setflag;
  } wb_entry_t;
endpackage

// File: rtl/alu_writeback_regfile_if.sv
// alu_writeback_regfile_if: operand read, ALU result handshake and load write-back bundle.
interface alu_writeback_regfile_if;
  import alu_writeback_regfile_pkg::*;
  logic [REG_ADDR_W-1:0] RA, RB, WbAddr, LdAddr;
  logic [DATA_W-1:0]     BusA, BusB, BusW, LdData;
  logic                  WbValid, WbReady, Zero, WbSetFlag, LdWrEn, ZeroFlag;
  logic [1:0]            WbPending;
  modport master (
    output RA, RB, WbValid, WbAddr, BusW, Zero, WbSetFlag, LdWrEn, LdAddr, LdData,
    input  BusA, BusB, WbReady, ZeroFlag, WbPending
  );
  modport slave (
    input  RA, RB, WbValid, WbAddr, BusW, Zero, WbSetFlag, LdWrEn, LdAddr, LdData,
    output BusA, BusB, WbReady, ZeroFlag, WbPending
  );
endinterface

// File: rtl/alu_writeback_regfile_wb_fifo.sv
// wb_fifo: write-back queue; exposes entries oldest-first with valid bits for forwarding search.
module wb_fifo
  import alu_writeback_regfile_pkg::*;
#(
  parameter int DEPTH = WBQ_DEPTH,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_push,
  input  wb_entry_t     i_data,
  input  logic          i_pop,
  output wb_entry_t     o_head,
  output logic [CW-1:0] o_count,
  output wb_entry_t     o_ent [DEPTH],
  output logic          o_vld [DEPTH]
);
  wb_entry_t     r_mem [DEPTH];
  logic [PW-1:0] r_wr, r_rd;
  logic [CW-1:0] r_count;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr] <= i_data;
        r_wr        <= r_wr + 1'b1;
      end
      if (i_pop) r_rd <= r_rd + 1'b1;
      r_count <= r_count + CW'(i_push) - CW'(i_pop);
    end
  end
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      o_ent[k] = r_mem[r_rd + PW'(k)];
      o_vld[k] = CW'(k) < r_count;
    end
  end
  assign o_head  = r_mem[r_rd];
  assign o_count = r_count;
endmodule

// File: rtl/alu_writeback_regfile.sv
// alu_writeback_regfile: LEGv8 register file fed by a write-back queue, with operand forwarding.
module alu_writeback_regfile
  import alu_writeback_regfile_pkg::*;
(
  input logic                    CLK,
  input logic                    ResetN,
  alu_writeback_regfile_if.slave bus
);
  localparam int CW = $clog2(WBQ_DEPTH) + 1;
  logic [DATA_W-1:0]     r_rf [NREGS];
  logic                  r_zf;
  wb_entry_t             w_head, w_in;
  wb_entry_t             w_ent [WBQ_DEPTH];
  logic                  w_vld [WBQ_DEPTH];
  logic [CW-1:0]         w_count;
  logic                  w_push, w_pop;
  logic [REG_ADDR_W-1:0] w_ra [2];
  logic [DATA_W-1:0]     w_rd [2];
  assign bus.WbReady   = w_count != CW'(WBQ_DEPTH);
  assign w_push        = bus.WbValid & bus.WbReady;
  assign w_pop         = (w_count != '0) & ~bus.LdWrEn;
  assign w_in          = '{addr: bus.WbAddr, data: bus.BusW, zero: bus.Zero, setflag: bus.WbSetFlag};
  assign bus.WbPending = 2'(w_count);
  assign bus.ZeroFlag  = r_zf;
  wb_fifo #(.DEPTH(WBQ_DEPTH)) u_fifo (
    .i_clk   (CLK),
    .i_rst_n (ResetN),
    .i_push  (w_push),
    .i_data  (w_in),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (w_count),
    .o_ent   (w_ent),
    .o_vld   (w_vld)
  );
  // Load and retire are mutually exclusive: retire only happens when LdWrEn is low.
  always_ff @(posedge CLK or negedge ResetN) begin
    if (!ResetN) begin
      for (int i = 0; i < NREGS; i++) r_rf[i] <= '0;
      r_zf <= 1'b0;
    end else begin
      if (bus.LdWrEn && bus.LdAddr != XZR) r_rf[bus.LdAddr] <= bus.LdData;
      if (w_pop && w_head.addr != XZR) r_rf[w_head.addr] <= w_head.data;
      if (w_pop && w_head.setflag) r_zf <= w_head.zero;
    end
  end
  assign w_ra[0] = bus.RA;
  assign w_ra[1] = bus.RB;
  // Entries are scanned oldest-first so the youngest match overrides.
  for (genvar p = 0; p < 2; p++) begin : g_rd
    always_comb begin
      w_rd[p] = r_rf[w_ra[p]];
      for (int k = 0; k < WBQ_DEPTH; k++)
        if (w_vld[k] && w_ent[k].addr == w_ra[p]) w_rd[p] = w_ent[k].data;
      if (w_ra[p] == XZR) w_rd[p] = '0;
    end
  end
  assign bus.BusA = w_rd[0];
  assign bus.BusB = w_rd[1];
endmodule

// File: tb/tb_alu_writeback_regfile.sv
// tb_alu_writeback_regfile: directed checks of queueing, forwarding, retire order, XZR and ZeroFlag.
module tb_alu_writeback_regfile;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  alu_writeback_regfile_if bus();
  alu_writeback_regfile dut (.CLK(clk), .ResetN(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic offer(input logic [4:0] a, input logic [63:0] d, input logic z, input logic sf);
    bus.WbValid = 1'b1; bus.WbAddr = a; bus.BusW = d; bus.Zero = z; bus.WbSetFlag = sf;
  endtask
  initial begin
    bus.RA = '0; bus.RB = '0; bus.WbValid = 0; bus.WbAddr = '0; bus.BusW = '0;
    bus.Zero = 0; bus.WbSetFlag = 0; bus.LdWrEn = 0; bus.LdAddr = '0; bus.LdData = '0;
    tick(); tick();
    rst_n = 1'b1;
    bus.RA = 5'd5;
    tick();
    chk("rst_ready", 64'(bus.WbReady), 64'd1);
    chk("rst_pending", 64'(bus.WbPending), 64'd0);
    chk("rst_zf", 64'(bus.ZeroFlag), 64'd0);
    chk("rst_busa", bus.BusA, 64'd0);
    // reset while X1 is still queued
    bus.LdWrEn = 1; bus.LdAddr = 5'd31; bus.RA = 5'd1;
    offer(5'd1, 64'd5, 1'b0, 1'b0);
    tick();
    bus.WbValid = 0;
    chk("q_pending", 64'(bus.WbPending), 64'd1);
    chk("q_fwd_x1", bus.BusA, 64'd5);
    rst_n = 1'b0;
    #1;
    chk("arst_busa", bus.BusA, 64'd0);
    chk("arst_pending", 64'(bus.WbPending), 64'd0);
    chk("arst_zf", 64'(bus.ZeroFlag), 64'd0);
    tick();
    rst_n = 1'b1; bus.LdWrEn = 0;
    tick();
    chk("post_rst_x1", bus.BusA, 64'd0);
    // basic write-back
    bus.RA = 5'd2; bus.RB = 5'd2;
    offer(5'd2, 64'h1234, 1'b0, 1'b0);
    tick();
    bus.WbValid = 0;
    chk("basic_pending1", 64'(bus.WbPending), 64'd1);
    chk("basic_fwd", bus.BusA, 64'h1234);
    tick();
    chk("basic_pending0", 64'(bus.WbPending), 64'd0);
    chk("basic_rf_a", bus.BusA, 64'h1234);
    chk("basic_rf_b", bus.BusB, 64'h1234);
    // youngest-entry forwarding
    bus.LdWrEn = 1; bus.LdAddr = 5'd31; bus.RA = 5'd3;
    offer(5'd3, 64'd7, 1'b0, 1'b0);
    tick();
    offer(5'd3, 64'd9, 1'b0, 1'b0);
    tick();
    bus.WbValid = 0;
    chk("fwd_pending2", 64'(bus.WbPending), 64'd2);
    chk("fwd_ready0", 64'(bus.WbReady), 64'd0);
    chk("fwd_young", bus.BusA, 64'd9);
    bus.LdWrEn = 0;
    tick();
    chk("fwd_pending1", 64'(bus.WbPending), 64'd1);
    chk("fwd_after1", bus.BusA, 64'd9);
    tick();
    chk("fwd_pending0", 64'(bus.WbPending), 64'd0);
    chk("fwd_rf", bus.BusA, 64'd9);
    // load data is not forwarded
    bus.LdWrEn = 1; bus.LdAddr = 5'd4; bus.LdData = 64'hABC; bus.RA = 5'd4;
    #1;
    chk("ld_nofwd", bus.BusA, 64'd0);
    tick();
    bus.LdWrEn = 0;
    chk("ld_rf", bus.BusA, 64'hABC);
    // full queue
    bus.LdWrEn = 1; bus.LdAddr = 5'd31;
    offer(5'd5, 64'h11, 1'b0, 1'b0);
    tick();
    offer(5'd6, 64'h22, 1'b0, 1'b0);
    tick();
    offer(5'd7, 64'h33, 1'b0, 1'b0);
    chk("full_ready0", 64'(bus.WbReady), 64'd0);
    chk("full_pending", 64'(bus.WbPending), 64'd2);
    tick();
    bus.WbValid = 0; bus.LdWrEn = 0; bus.RA = 5'd5; bus.RB = 5'd6;
    tick();
    chk("full_ret1_pend", 64'(bus.WbPending), 64'd1);
    chk("full_ret1_x5", bus.BusA, 64'h11);
    chk("full_ret1_x6", bus.BusB, 64'h22);
    tick();
    bus.RA = 5'd7;
    #1;
    chk("full_ret2_pend", 64'(bus.WbPending), 64'd0);
    chk("full_x7_drop", bus.BusA, 64'd0);
    // XZR write with flag
    bus.RA = 5'd31;
    offer(5'd31, 64'hFFFF, 1'b1, 1'b1);
    tick();
    bus.WbValid = 0;
    chk("xzr_zf_enq", 64'(bus.ZeroFlag), 64'd0);
    chk("xzr_fwd", bus.BusA, 64'd0);
    tick();
    chk("xzr_zf", 64'(bus.ZeroFlag), 64'd1);
    chk("xzr_rd", bus.BusA, 64'd0);
    // flag only changes on setflag retire
    offer(5'd8, 64'd1, 1'b1, 1'b1);
    tick();
    offer(5'd9, 64'd2, 1'b0, 1'b0);
    tick();
    bus.WbValid = 0;
    tick();
    chk("flag_keep", 64'(bus.ZeroFlag), 64'd1);
    bus.LdWrEn = 1; bus.LdAddr = 5'd11; bus.LdData = 64'd0;
    tick();
    bus.LdWrEn = 0;
    chk("flag_ld", 64'(bus.ZeroFlag), 64'd1);
    offer(5'd10, 64'd3, 1'b0, 1'b1);
    tick();
    bus.WbValid = 0;
    tick();
    chk("flag_clr", 64'(bus.ZeroFlag), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
